// File: rtl/ask4_symbol_upsampler.sv
// rtl/ask4_symbol_upsampler.sv - 4-ASK PRBS symbol source, 1s17 level map, zero-stuffed by 4.
// Optional test patterns (constant, alternating, impulse) are selected by sw under `TEST_PATTERN_EN.
module ask4_symbol_upsampler (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         sw,
  output logic signed [17:0] x_out,
  output logic               sym_strobe,
  output logic [1:0]         sym_out
);

  localparam logic signed [17:0] LVL_N3 = -18'sd98304;
  localparam logic signed [17:0] LVL_N1 = -18'sd32768;
  localparam logic signed [17:0] LVL_P1 = 18'sd32768;
  localparam logic signed [17:0] LVL_P3 = 18'sd98304;

  logic [1:0]  phase;
  logic [14:0] lfsr;
  logic [1:0]  sym_sel;
  logic        sym_zero;
  logic signed [17:0] sym_level;

  always_comb begin
    sym_level = LVL_N3;
    case (sym_sel)
      2'b00:   sym_level = LVL_N3;
      2'b01:   sym_level = LVL_N1;
      2'b10:   sym_level = LVL_P1;
      default: sym_level = LVL_P3;
    endcase
  end

`ifdef TEST_PATTERN_EN
  logic       alt;
  logic       imp_done;
  logic [1:0] sw_d;
  logic       imp_armed;

  // A change of sw on this very edge re-arms the impulse before it is consumed.
  assign imp_armed = !imp_done || (sw != sw_d);

  always_comb begin
    sym_sel  = lfsr[1:0];
    sym_zero = 1'b0;
    case (sw)
      2'b01:   sym_sel = 2'b11;
      2'b10:   sym_sel = alt ? 2'b00 : 2'b11;
      2'b11: begin
        sym_sel  = 2'b11;
        sym_zero = !imp_armed;
      end
      default: sym_sel = lfsr[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alt      <= 1'b0;
      imp_done <= 1'b0;
      sw_d     <= sw;
    end else if (en) begin
      sw_d <= sw;
      if (sw != sw_d)
        imp_done <= 1'b0;
      if (phase == 2'd0) begin
        alt <= !alt;
        if (sw == 2'b11 && imp_armed)
          imp_done <= 1'b1;
      end
    end
  end
`else
  logic unused_sw;
  assign unused_sw = ^sw;
  assign sym_sel   = lfsr[1:0];
  assign sym_zero  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      x_out      <= '0;
      sym_strobe <= 1'b0;
      sym_out    <= 2'b00;
      phase      <= 2'd0;
      lfsr       <= 15'h0001;
    end else if (en) begin
      phase <= phase + 2'd1;
      if (phase == 2'd0) begin
        x_out      <= sym_zero ? 18'sd0 : sym_level;
        sym_out    <= sym_sel;
        sym_strobe <= 1'b1;
        lfsr       <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
      end else begin
        x_out      <= '0;
        sym_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ask4_symbol_upsampler.md
# ask4_symbol_upsampler

Generates the 4-ASK transmit sample stream that drives the SRRC pulse-shaping filter's `x_in`. A 15-bit PRBS produces 2-bit symbols, which are mapped to 1s17 amplitude levels and zero-stuffed by 4 (one symbol every 4 enabled samples). It also emits a symbol strobe and the symbol index for the downstream slicer and BER checker. Output values are exactly the set the filter's LUTs decode: 0, ±32768, ±98304.

## Interface
- No parameters; the upsample factor (4), LFSR length (15) and seed (15'h0001) are fixed.
- `clk` in 1: sample clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: sample enable. When low, all state holds.
- `sw` in 2: test-pattern select. Used only with `TEST_PATTERN_EN`.
- `x_out` out 18 signed: 1s17 sample to the filter's `x_in`.
- `sym_strobe` out 1: high for the one enabled sample carrying a symbol.
- `sym_out` out 2: index of the most recent symbol, held between strobes.

## Operation
- **State**
  - `phase`: 2-bit counter.
  - `lfsr[14:0]`: PRBS register.
  - `alt`: toggle flop.
  - `imp_done`: impulse flag.
  - `sw_d`: registered copy of `sw`.
- **Level map** (symbol index → 1s17):
  - 00 → −98304
  - 01 → −32768
  - 10 → +32768
  - 11 → +98304
- **Symbol edge**: a rising edge with `en`=1, `reset`=0 and `phase`=0.
  - `x_out` ← map(selected symbol).
  - `sym_out` ← selected symbol.
  - `sym_strobe` ← 1.
  - `lfsr` ← {lfsr[13:0], lfsr[14]^lfsr[13]}.
  - `phase` ← 1.
- **Zero edges**: edges with `en`=1 and `phase`≠0.
  - `x_out` ← 0, `sym_strobe` ← 0.
  - `phase` increments and wraps 3→0.
  - `sym_out` holds.
- **`en`=0**: all registers hold, including `x_out` and `sym_strobe`.
  - The downstream filter must be clocked with the same enable.
- **PRBS**
  - Polynomial x^15+x^14+1, period 32767, never reaches all-zero.
  - The symbol is `lfsr[1:0]` sampled before the shift.
  - The LFSR advances on every symbol edge in all modes, so PRBS alignment is mode-independent.
- **Arithmetic**: none beyond the map; no saturation is required, and 18-bit signed constants are exact.

## Timing
- **Reset values** (asserted at an edge):
  - `x_out`=0, `sym_strobe`=0, `sym_out`=2'b00.
  - `phase`=0, `lfsr`=15'h0001.
  - `alt`=0, `imp_done`=0, `sw_d`=`sw`.
- **Reset mid-symbol**: it aborts the current zero-stuffing. The first enabled edge after release is a symbol edge.
- **Latency**: one register. Outputs change only on rising `clk`; there is no combinational path from input to output.
- **Symbol rate**: one per 4 enabled edges. `sym_strobe` is exactly 1 of every 4 enabled samples.
- **Simultaneous reset and `en`**: reset wins.

## Configuration
- **Macro**: `TEST_PATTERN_EN`.
- **Defined**: `sw` selects the symbol source, evaluated at each symbol edge.
  - 00: PRBS `lfsr[1:0]`.
  - 01: constant 11 (+98304).
  - 10: alternating. Emits 11 when `alt`=0, otherwise 00; `alt` toggles each symbol edge; first symbol after reset is +98304.
  - 11: single impulse. Emits 11 on the first symbol edge with `imp_done`=0, then sets `imp_done`. All subsequent symbols output `x_out`=0 while `sym_strobe` still pulses and `sym_out`=11.
  - `imp_done` clears on reset, or on any enabled edge where `sw`≠`sw_d`.
  - `sw_d` ← `sw` on every enabled edge.
- **Undefined**: `sw` is ignored, the source is always PRBS, and the `alt`, `imp_done` and `sw_d` logic is absent.

## Test plan
- **Reset, then PRBS**: reset 2 cycles, then `en`=1, `sw`=00.
  - `x_out` sequence −32768, 0, 0, 0, +32768, 0, 0, 0, −98304, 0, 0, 0, −98304.
  - `sym_strobe` high on edges 0, 4, 8, 12.
- **Enable gating**: PRBS running with `en` low for 5 cycles after edge 1.
  - All outputs frozen.
  - The next symbol appears on the third enabled edge after `en` returns high.
- **Reset mid-operation**: assert reset at `phase`=2.
  - Outputs go to 0 at that edge.
  - The first post-release edge reproduces −32768 with `sym_strobe`=1.
- **PRBS period**: run 4×32767 enabled edges.
  - `lfsr` returns to 15'h0001.
  - The symbol sequence repeats exactly.
  - `x_out` is never outside {0, ±32768, ±98304}.
- **`TEST_PATTERN_EN`, `sw`=10 then 01**:
  - `sw`=10 gives symbols +98304, −98304, +98304, …
  - `sw`=01 gives +98304 on every symbol edge.
- **`TEST_PATTERN_EN`, `sw`=11 impulse**:
  - One +98304, followed by zeros only.
  - Switch to 00 and back to 11: exactly one new +98304 at the next symbol edge.
